// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_rst_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int LOSS_CNT_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level, reset to 0.
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives the PLL reset and produces a lock-qualified system reset on refclk.
// Define PLL_RST_SEQ_LOSS_CNT_EN to add the saturating loss_count output.
module pll_reset_sequencer
  import pll_rst_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic                  sys_rst,
  output logic                  ready,
  output logic                  timeout_err
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  ,
  output logic [LOSS_CNT_W-1:0] loss_count
`endif
);

  localparam int CNT_W = $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_locked_s;
  logic             w_timeout;
  logic             r_pll_rst;
  logic             r_sys_rst;
  logic             r_ready;
  logic             r_timeout_err;

  sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk(refclk),
    .rst(rst),
    .i_d(pll_locked),
    .o_q(w_locked_s)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      PLL_RST: begin
        if (r_cnt == PLL_RST_LAST) w_state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock wins over a coincident timeout.
        if (w_locked_s) begin
          w_state_nxt = STABLE;
        end else if (r_cnt == LOCK_LAST) begin
          w_state_nxt = PLL_RST;
          w_timeout   = 1'b1;
        end
      end
      STABLE: begin
        if (!w_locked_s)                w_state_nxt = PLL_RST;
        else if (r_cnt == STABLE_LAST)  w_state_nxt = RUN;
      end
      RUN: begin
        if (!w_locked_s) w_state_nxt = PLL_RST;
      end
      default: w_state_nxt = PLL_RST;
    endcase
  end

  // Outputs are registered from the next state so they change on the transition edge.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state       <= PLL_RST;
      r_cnt         <= '0;
      r_pll_rst     <= 1'b1;
      r_sys_rst     <= 1'b1;
      r_ready       <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pll_rst     <= (w_state_nxt == PLL_RST);
      r_sys_rst     <= (w_state_nxt != RUN);
      r_ready       <= (w_state_nxt == RUN);
      r_timeout_err <= w_timeout;
      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (r_state != RUN)    r_cnt <= r_cnt + 1'b1;
    end
  end

  assign pll_rst     = r_pll_rst;
  assign sys_rst     = r_sys_rst;
  assign ready       = r_ready;
  assign timeout_err = r_timeout_err;

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  logic                  w_loss;
  logic [LOSS_CNT_W-1:0] r_loss_cnt;

  // Drops during STABLE are not losses; only a loss from RUN is counted.
  assign w_loss = (r_state == RUN) && !w_locked_s;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst)                                r_loss_cnt <= '0;
    else if (w_loss && (r_loss_cnt != '1))  r_loss_cnt <= r_loss_cnt + 1'b1;
  end

  assign loss_count = r_loss_cnt;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: stimulus queues expected output edges, a monitor pops them on every change.
module tb_pll_reset_sequencer;

  localparam int P_RST  = 4;
  localparam int P_TO   = 32;
  localparam int P_ST   = 8;
  localparam int P_SYNC = 2;

  localparam int S_PLL = 0;
  localparam int S_SYS = 1;
  localparam int S_RDY = 2;
  localparam int S_TO  = 3;

  typedef struct {
    int sig;
    bit val;
    int cyc;
  } ev_t;

  logic refclk     = 1'b0;
  logic rst        = 1'b1;
  logic pll_locked = 1'b1;
  logic pll_rst;
  logic sys_rst;
  logic ready;
  logic timeout_err;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  logic [7:0] loss_count;
`endif

  ev_t      exp_q[$];
  int       n_checks = 0;
  int       n_errors = 0;
  int       cyc      = 0;
  logic [3:0] prev   = 4'b0011;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(P_RST),
    .LOCK_TIMEOUT  (P_TO),
    .STABLE_CYCLES (P_ST),
    .SYNC_STAGES   (P_SYNC)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .timeout_err(timeout_err)
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    ,
    .loss_count (loss_count)
`endif
  );

  always #5 refclk = ~refclk;

  always @(posedge refclk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ev_key(input int s, input logic v, input int c);
    return {s[3:0], 3'b000, v, c[23:0]};
  endfunction

  task automatic push(input int s, input bit v, input int c);
    ev_t e;
    e.sig = s;
    e.val = v;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic push_loss(input int c);
    push(S_PLL, 1'b1, c);
    push(S_SYS, 1'b1, c);
    push(S_RDY, 1'b0, c);
  endtask

  task automatic push_release(input int c);
    push(S_SYS, 1'b0, c);
    push(S_RDY, 1'b1, c);
  endtask

  task automatic at_neg(input int c);
    do @(negedge refclk); while (cyc < c);
  endtask

  task automatic phase_end(input string nm);
    check($sformatf("%s pending events", nm), exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: every output edge must match the head of the expected queue.
  always @(negedge refclk) begin
    logic [3:0] now;
    ev_t        e;
    now = {timeout_err, ready, sys_rst, pll_rst};
    for (int s = 0; s < 4; s++) begin
      if (now[s] !== prev[s]) begin
        if (exp_q.size() == 0) begin
          check($sformatf("unexpected edge sig%0d", s), ev_key(s, now[s], cyc), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("edge sig%0d=%0d@%0d", e.sig, e.val, e.cyc),
                ev_key(s, now[s], cyc), ev_key(e.sig, e.val, e.cyc));
        end
      end
    end
    prev = now;
  end

  initial begin
    int b;
    int w;
    int x;
    int p;
    int r;

    // Reset state
    repeat (3) @(negedge refclk);
    check("reset pll_rst", pll_rst, 1);
    check("reset sys_rst", sys_rst, 1);
    check("reset ready", ready, 0);
    check("reset timeout_err", timeout_err, 0);
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    check("reset loss_count", loss_count, 0);
`endif

    // Normal bring-up with lock present from reset
    b = cyc;
    push(S_PLL, 1'b0, b + 4);
    push_release(b + 13);
    rst = 1'b0;
    at_neg(b + 20);
    phase_end("bringup");

    // Loss in RUN, then relock
    b = cyc;
    pll_locked = 1'b0;
    push_loss(b + 3);
    at_neg(b + 3);
    pll_locked = 1'b1;
    push(S_PLL, 1'b0, b + 7);
    push_release(b + 16);
    at_neg(b + 10);
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    check("loss_count after first loss", loss_count, 1);
`endif
    at_neg(b + 22);
    phase_end("loss_in_run");
    check("ready after relock", ready, 1);

    // No lock: three timeout periods of 36 cycles
    b = cyc;
    pll_locked = 1'b0;
    push_loss(b + 3);
    push(S_PLL, 1'b0, b + 7);
    for (int k = 0; k < 3; k++) begin
      push(S_PLL, 1'b1, b + 39 + 36 * k);
      push(S_TO,  1'b1, b + 39 + 36 * k);
      push(S_TO,  1'b0, b + 40 + 36 * k);
      push(S_PLL, 1'b0, b + 43 + 36 * k);
    end
    at_neg(b + 60);
    check("sys_rst held during retries", sys_rst, 1);

    // Glitch during STABLE: lock back in WAIT_LOCK, drop for 3 cycles
    w = b + 115;
    at_neg(w);
    pll_locked = 1'b1;
    at_neg(w + 5);
    pll_locked = 1'b0;
    push(S_PLL, 1'b1, w + 8);
    push(S_PLL, 1'b0, w + 12);
    push_release(w + 21);
    at_neg(w + 8);
    pll_locked = 1'b1;
    at_neg(w + 26);
    phase_end("nolock_glitch");
    check("ready after glitch recovery", ready, 1);
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    check("loss_count ignores STABLE glitch", loss_count, 2);
`endif

    // Repeated losses in RUN drive the counter into saturation
    for (int i = 0; i < 300; i++) begin
      x = cyc;
      pll_locked = 1'b0;
      push_loss(x + 3);
      at_neg(x + 3);
      pll_locked = 1'b1;
      push(S_PLL, 1'b0, x + 7);
      push_release(x + 16);
      at_neg(x + 20);
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
      if (i == 251) check("loss_count at 254", loss_count, 254);
      if (i == 252) check("loss_count at 255", loss_count, 255);
      if (i == 299) check("loss_count saturated", loss_count, 255);
`endif
    end
    phase_end("saturation");

    // Asynchronous reset in RUN, then restart with lock arriving on the timeout cycle
    @(posedge refclk);
    #2;
    p = cyc;
    push_loss(p);
    rst        = 1'b1;
    pll_locked = 1'b0;
    #1;
    check("async rst pll_rst", pll_rst, 1);
    check("async rst sys_rst", sys_rst, 1);
    check("async rst ready", ready, 0);
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    check("async rst loss_count", loss_count, 0);
`endif
    at_neg(p + 3);
    r = cyc;
    push(S_PLL, 1'b0, r + 4);
    push_release(r + 44);
    rst = 1'b0;
    at_neg(r + 33);
    pll_locked = 1'b1;
    at_neg(r + 50);
    phase_end("restart");
    check("ready after restart", ready, 1);
    check("timeout_err idle", timeout_err, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
